// File: rtl/cpu_bus_if_pkg.sv
// Shared CPU definitions: word-bus and SPM widths, SPM region, and the
// bus-interface FSM state encoding.
package cpu_bus_if_pkg;

    localparam int WORD_DATA_W = 32;
    localparam int WORD_ADDR_W = 30;

    localparam int SPM_ADDR_W = 12;
    localparam int SPM_DEPTH  = 1 << SPM_ADDR_W;

    // Address bits [29:27] pick the memory region.
    localparam int REGION_MSB = 29;
    localparam int REGION_LSB = 27;
    localparam logic [2:0] SPM_REGION_DEF = 3'b011;

    typedef enum logic [1:0] {
        BUS_IF_IDLE   = 2'd0,
        BUS_IF_REQ    = 2'd1,
        BUS_IF_ACCESS = 2'd2,
        BUS_IF_STALL  = 2'd3
    } bus_if_state_e;

    function automatic logic is_region(input logic [WORD_ADDR_W-1:0] a,
                                       input logic [2:0]             region);
        return a[REGION_MSB:REGION_LSB] == region;
    endfunction

endpackage

// File: rtl/cpu_bus_if.sv
// Per-stage bus interface: SPM hits go straight to the scratch-pad, all other
// accesses run a req/grant/ready handshake on the shared external bus.
module cpu_bus_if
    import cpu_bus_if_pkg::*;
#(
    parameter logic [2:0] SPM_REGION = SPM_REGION_DEF,
    parameter int         SPM_AW     = SPM_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   busy,
    input  logic [WORD_ADDR_W-1:0] addr,
    input  logic                   as_n,
    input  logic                   rw,
    input  logic [WORD_DATA_W-1:0] wr_data,
    output logic [WORD_DATA_W-1:0] rd_data,
    output logic [SPM_AW-1:0]      spm_addr,
    output logic                   spm_as_n,
    output logic                   spm_rw,
    output logic [WORD_DATA_W-1:0] spm_wr_data,
    input  logic [WORD_DATA_W-1:0] spm_rd_data,
    output logic                   bus_req_n,
    input  logic                   bus_grnt_n,
    output logic [WORD_ADDR_W-1:0] bus_addr,
    output logic                   bus_as_n,
    output logic                   bus_rw,
    output logic [WORD_DATA_W-1:0] bus_wr_data,
    input  logic [WORD_DATA_W-1:0] bus_rd_data,
    input  logic                   bus_rdy_n
);

    bus_if_state_e          state_reg;
    logic [WORD_DATA_W-1:0] rd_buf_reg;
    logic                   spm_hit;
    logic                   valid;

    assign spm_hit = is_region(addr, SPM_REGION);
    assign valid   = !as_n && !flush;

    assign spm_addr    = addr[SPM_AW-1:0];
    assign spm_rw      = rw;
    assign spm_wr_data = wr_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= BUS_IF_IDLE;
            bus_req_n   <= 1'b1;
            bus_as_n    <= 1'b1;
            bus_addr    <= '0;
            bus_rw      <= 1'b0;
            bus_wr_data <= '0;
            rd_buf_reg  <= '0;
        end else begin
            // Strobe is a single-cycle pulse; only the grant edge re-asserts it.
            bus_as_n <= 1'b1;
            case (state_reg)
                BUS_IF_IDLE: begin
                    if (valid && !spm_hit) begin
                        bus_addr    <= addr;
                        bus_rw      <= rw;
                        bus_wr_data <= wr_data;
                        bus_req_n   <= 1'b0;
                        state_reg   <= BUS_IF_REQ;
                    end
                end
                BUS_IF_REQ: begin
                    if (!bus_grnt_n) begin
                        bus_as_n  <= 1'b0;
                        state_reg <= BUS_IF_ACCESS;
                    end
                end
                BUS_IF_ACCESS: begin
                    if (!bus_rdy_n) begin
                        bus_req_n  <= 1'b1;
                        rd_buf_reg <= bus_rd_data;
                        state_reg  <= stall ? BUS_IF_STALL : BUS_IF_IDLE;
                    end
                end
                BUS_IF_STALL: begin
                    if (!stall) begin
                        state_reg <= BUS_IF_IDLE;
                    end
                end
                default: state_reg <= BUS_IF_IDLE;
            endcase
        end
    end

    // SPM strobe is only ever asserted from IDLE, so it can never overlap an
    // external access in flight.
    always_comb begin
        busy     = 1'b0;
        rd_data  = '0;
        spm_as_n = 1'b1;
        case (state_reg)
            BUS_IF_IDLE: begin
                if (valid && spm_hit) begin
                    spm_as_n = 1'b0;
                    rd_data  = spm_rd_data;
                end else if (valid) begin
                    busy = 1'b1;
                end
            end
            BUS_IF_REQ: begin
                busy = 1'b1;
            end
            BUS_IF_ACCESS: begin
                if (!bus_rdy_n) begin
                    rd_data = bus_rd_data;
                end else begin
                    busy = 1'b1;
                end
            end
            BUS_IF_STALL: begin
                rd_data = rd_buf_reg;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_bus_if.sv
// Directed plus randomized bench for cpu_bus_if with a scripted bus slave and
// arithmetic latency model.
module tb_cpu_bus_if;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        busy;
    logic [29:0] addr;
    logic        as_n;
    logic        rw;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [11:0] spm_addr;
    logic        spm_as_n;
    logic        spm_rw;
    logic [31:0] spm_wr_data;
    logic [31:0] spm_rd_data;
    logic        bus_req_n;
    logic        bus_grnt_n;
    logic [29:0] bus_addr;
    logic        bus_as_n;
    logic        bus_rw;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_n;

    int checks = 0;
    int errors = 0;

    cpu_bus_if dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .busy       (busy),
        .addr       (addr),
        .as_n       (as_n),
        .rw         (rw),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .spm_addr   (spm_addr),
        .spm_as_n   (spm_as_n),
        .spm_rw     (spm_rw),
        .spm_wr_data(spm_wr_data),
        .spm_rd_data(spm_rd_data),
        .bus_req_n  (bus_req_n),
        .bus_grnt_n (bus_grnt_n),
        .bus_addr   (bus_addr),
        .bus_as_n   (bus_as_n),
        .bus_rw     (bus_rw),
        .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data),
        .bus_rdy_n  (bus_rdy_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step to the next cycle: inputs change 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // SPM access in the current IDLE cycle; hit decided from the region bits.
    task automatic spm_access(input logic [29:0] a, input logic r_w, input logic [31:0] wd);
        logic [31:0] sd;
        sd = $urandom;
        addr = a; rw = r_w; wr_data = wd; as_n = 1'b0; flush = 1'b0;
        spm_rd_data = sd;
        #3;
        chk("spm_as_n", {31'd0, spm_as_n}, 32'd0);
        chk("spm_addr", {20'd0, spm_addr}, {20'd0, a[11:0]});
        chk("spm_busy", {31'd0, busy}, 32'd0);
        chk("spm_rd_data", rd_data, sd);
        chk("spm_rw", {31'd0, spm_rw}, {31'd0, r_w});
        chk("spm_wr_data", spm_wr_data, wd);
        chk("spm_bus_req_n", {31'd0, bus_req_n}, 32'd1);
        next_cycle();
        as_n = 1'b1;
        #3;
        chk("spm_after_req_n", {31'd0, bus_req_n}, 32'd1);
        chk("spm_after_busy", {31'd0, busy}, 32'd0);
        next_cycle();
    endtask

    // External access: grant arrives in the g-th request cycle, ready r cycles
    // after the cycle following the strobe cycle; stall held for h cycles.
    task automatic ext_access(input logic [29:0] a, input logic r_w, input logic [31:0] wd,
                              input int g, input int r, input int h, input logic fl_mid,
                              input logic [31:0] rdv);
        int busy_cnt;
        int as_cnt;
        int exp_busy;
        busy_cnt = 0;
        as_cnt   = 0;
        exp_busy = 1 + g + 1 + r;
        addr = a; rw = r_w; wr_data = wd; as_n = 1'b0; flush = 1'b0;
        bus_grnt_n = 1'b1; bus_rdy_n = 1'b1; stall = 1'b0;
        #3;
        if (busy) busy_cnt++;
        chk("issue_spm_as_n", {31'd0, spm_as_n}, 32'd1);
        next_cycle();
        // The stage moves on; the registered bus copy must not follow it.
        as_n = 1'b1; flush = fl_mid; addr = $urandom; wr_data = $urandom; rw = ~r_w;
        for (int i = 1; i <= g; i++) begin
            bus_grnt_n = (i == g) ? 1'b0 : 1'b1;
            #3;
            if (busy) busy_cnt++;
            if (!bus_as_n) as_cnt++;
            chk("req_bus_req_n", {31'd0, bus_req_n}, 32'd0);
            chk("req_bus_addr", {2'd0, bus_addr}, {2'd0, a});
            next_cycle();
        end
        bus_grnt_n = 1'b1;
        for (int i = 0; i <= r; i++) begin
            #3;
            if (busy) busy_cnt++;
            if (!bus_as_n) as_cnt++;
            chk("acc_spm_as_n", {31'd0, spm_as_n}, 32'd1);
            chk("acc_bus_rw", {31'd0, bus_rw}, {31'd0, r_w});
            chk("acc_bus_wr_data", bus_wr_data, wd);
            next_cycle();
        end
        bus_rdy_n = 1'b0; bus_rd_data = rdv; stall = (h > 0);
        #3;
        if (!bus_as_n) as_cnt++;
        chk("rdy_busy", {31'd0, busy}, 32'd0);
        if (r_w) chk("rdy_rd_data", rd_data, rdv);
        chk("rdy_bus_wr_data", bus_wr_data, wd);
        chk("busy_cycles", busy_cnt, exp_busy);
        chk("strobe_cycles", as_cnt, 1);
        next_cycle();
        bus_rdy_n = 1'b1; bus_rd_data = $urandom;
        for (int i = 1; i < h; i++) begin
            #3;
            chk("stall_busy", {31'd0, busy}, 32'd0);
            if (r_w) chk("stall_rd_data", rd_data, rdv);
            chk("stall_bus_req_n", {31'd0, bus_req_n}, 32'd1);
            next_cycle();
            bus_rd_data = $urandom;
        end
        if (h > 0) begin
            stall = 1'b0;
            #3;
            if (r_w) chk("unstall_rd_data", rd_data, rdv);
            next_cycle();
        end
        flush = 1'b0;
        #3;
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_rd_data", rd_data, 32'd0);
        chk("done_bus_req_n", {31'd0, bus_req_n}, 32'd1);
        chk("done_bus_as_n", {31'd0, bus_as_n}, 32'd1);
        next_cycle();
    endtask

    initial begin
        logic [29:0] ra;
        reset = 1'b1; stall = 1'b0; flush = 1'b0; addr = '0; as_n = 1'b1;
        rw = 1'b1; wr_data = '0; spm_rd_data = '0; bus_grnt_n = 1'b1;
        bus_rd_data = '0; bus_rdy_n = 1'b1;
        #3;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_spm_as_n", {31'd0, spm_as_n}, 32'd1);
        chk("rst_bus_req_n", {31'd0, bus_req_n}, 32'd1);
        chk("rst_bus_as_n", {31'd0, bus_as_n}, 32'd1);
        chk("rst_bus_addr", {2'd0, bus_addr}, 32'd0);
        chk("rst_bus_rw", {31'd0, bus_rw}, 32'd0);
        chk("rst_bus_wr_data", bus_wr_data, 32'd0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        next_cycle();

        spm_access(30'h1800_0004, 1'b1, 32'h0);
        ext_access(30'h0000_0010, 1'b1, 32'h0, 2, 3, 0, 1'b0, 32'hDEADBEEF);
        ext_access(30'h0000_0010, 1'b1, 32'h0, 2, 3, 4, 1'b0, 32'hDEADBEEF);

        // Flush in IDLE suppresses an external request.
        addr = 30'h0000_0020; as_n = 1'b0; flush = 1'b1; rw = 1'b1;
        #3;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_spm_as_n", {31'd0, spm_as_n}, 32'd1);
        next_cycle();
        #3;
        chk("flush_bus_req_n", {31'd0, bus_req_n}, 32'd1);
        as_n = 1'b1; flush = 1'b0;
        next_cycle();

        ext_access(30'h0000_0040, 1'b1, 32'h0, 1, 1, 0, 1'b1, 32'hCAFE0001);
        ext_access(30'h0000_0044, 1'b0, 32'h12345678, 3, 2, 0, 1'b0, 32'h0BAD0BAD);
        ext_access(30'h0000_0048, 1'b1, 32'h0, 1, 0, 1, 1'b0, 32'h55AA55AA);

        // Asynchronous reset between edges during ACCESS.
        addr = 30'h0000_0080; rw = 1'b1; as_n = 1'b0; bus_grnt_n = 1'b1;
        next_cycle();
        as_n = 1'b1; bus_grnt_n = 1'b0;
        next_cycle();
        bus_grnt_n = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_bus_req_n", {31'd0, bus_req_n}, 32'd1);
        chk("arst_bus_as_n", {31'd0, bus_as_n}, 32'd1);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_bus_addr", {2'd0, bus_addr}, 32'd0);
        #3;
        reset = 1'b0;
        next_cycle();
        #3;
        chk("post_arst_busy", {31'd0, busy}, 32'd0);
        chk("post_arst_req_n", {31'd0, bus_req_n}, 32'd1);
        next_cycle();

        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            if (n % 2 == 0) ra[29:27] = 3'b011;
            if (ra[29:27] == 3'b011)
                spm_access(ra, 1'($urandom_range(0, 1)), $urandom);
            else
                ext_access(ra, 1'($urandom_range(0, 1)), $urandom,
                           $urandom_range(1, 4), $urandom_range(0, 4),
                           $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
